// File: rtl/reverse_convertor.sv
// Multi-cycle code converter: Gray, two-digit BCD or Excess-3 operand to binary.
// One operand is captured per request; the result and its validity flag are published from CHECK.
module reverse_convertor (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] sel,
    input  logic [7:0] code_in,
    output logic [6:0] bin_out,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CONV  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] SEL_GRAY = 2'b00;
    localparam logic [1:0] SEL_BCD  = 2'b01;
    localparam logic [1:0] SEL_XS3  = 2'b10;

    state_t     state_reg, state_next;
    logic [1:0] sel_reg;
    logic [7:0] code_reg;
    logic [6:0] acc_reg, acc_next;
    logic [1:0] cnt_reg;
    logic [6:0] bin_reg;
    logic       err_reg, err_next;
    logic [3:0] tens, units;

    assign tens  = code_reg[7:4];
    assign units = code_reg[3:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_CONV;
            ST_CONV:  if (cnt_reg == 2'd3) state_next = ST_CHECK;
            ST_CHECK: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // One conversion step per CONV cycle, selected by the iteration counter.
    always_comb begin
        acc_next = acc_reg;
        case (sel_reg)
            SEL_GRAY: begin
                case (cnt_reg)
                    2'd0: acc_next[3] = code_reg[3];
                    2'd1: acc_next[2] = acc_reg[3] ^ code_reg[2];
                    2'd2: acc_next[1] = acc_reg[2] ^ code_reg[1];
                    default: acc_next[0] = acc_reg[1] ^ code_reg[0];
                endcase
            end
            SEL_BCD: begin
                case (cnt_reg)
                    2'd0: acc_next = {tens, 3'b000};
                    2'd1: acc_next = acc_reg + {2'b00, tens, 1'b0};
                    2'd2: acc_next = acc_reg + {3'b000, units};
                    default: acc_next = acc_reg;
                endcase
            end
            SEL_XS3: begin
                if (cnt_reg == 2'd0) acc_next = {3'b000, units - 4'd3};
            end
            default: acc_next = acc_reg;
        endcase
    end

    always_comb begin
        err_next = 1'b0;
        case (sel_reg)
            SEL_GRAY: err_next = 1'b0;
            SEL_BCD:  err_next = (tens > 4'd9) || (units > 4'd9);
            SEL_XS3:  err_next = (units < 4'd3) || (units > 4'd12);
            default:  err_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            sel_reg   <= 2'b00;
            code_reg  <= 8'h00;
            acc_reg   <= 7'd0;
            cnt_reg   <= 2'd0;
            bin_reg   <= 7'd0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        sel_reg  <= sel;
                        code_reg <= code_in;
                    end
                end
                ST_LOAD: begin
                    acc_reg <= 7'd0;
                    cnt_reg <= 2'd0;
                end
                ST_CONV: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + 2'd1;
                end
                ST_CHECK: begin
                    err_reg <= err_next;
                    bin_reg <= err_next ? 7'd0 : acc_reg;
                end
                default: ;
            endcase
        end
    end

    assign bin_out = bin_reg;
    assign err     = err_reg;
    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign state   = state_reg;

endmodule

// File: tb/tb_reverse_convertor.sv
// Directed and random checks of reverse_convertor against an arithmetic reference model.
module tb_reverse_convertor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] sel;
    logic [7:0] code_in;
    logic [6:0] bin_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] state;

    int         compared;
    int         mismatched;
    logic [6:0] prev_bin;
    logic       prev_err;

    reverse_convertor dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sel     (sel),
        .code_in (code_in),
        .bin_out (bin_out),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: Gray by prefix XOR, BCD by decimal weight, Excess-3 by subtraction.
    function automatic void ref_model(input logic [1:0] s, input logic [7:0] c,
                                      output logic [6:0] b, output logic e);
        int t, u;
        t = int'(c[7:4]);
        u = int'(c[3:0]);
        b = 7'd0;
        e = 1'b0;
        case (s)
            2'b00: b = 7'(u ^ (u >> 1) ^ (u >> 2) ^ (u >> 3));
            2'b01: if (t > 9 || u > 9) e = 1'b1; else b = 7'(t * 10 + u);
            2'b10: if (u < 3 || u > 12) e = 1'b1; else b = 7'(u - 3);
            default: e = 1'b1;
        endcase
    endfunction

    // Called #1 after the accepting edge; walks the six edges up to DONE and back to IDLE.
    task automatic finish_conv(input logic [6:0] eb, input logic ee);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k < 6) begin
                check("done_early", done, 1'b0);
                check("busy_mid", busy, 1'b1);
                check("bin_hold", bin_out, prev_bin);
                check("err_hold", err, prev_err);
            end else begin
                check("done_pulse", done, 1'b1);
                check("state_done", state, 3'd4);
                check("bin_out", bin_out, eb);
                check("err", err, ee);
            end
        end
        prev_bin = eb;
        prev_err = ee;
        @(posedge clk); #1;
        check("state_idle", state, 3'd0);
        check("done_low", done, 1'b0);
        check("busy_low", busy, 1'b0);
        $display("conv result bin_out=%0d err=%0b (expected %0d/%0b)", bin_out, err, eb, ee);
    endtask

    task automatic run_conv(input logic [1:0] s, input logic [7:0] c);
        logic [6:0] eb;
        logic       ee;
        ref_model(s, c, eb, ee);
        @(negedge clk);
        sel = s; code_in = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sel = 2'($urandom);
        code_in = 8'($urandom);
        $display("start sel=%0d code_in=%02h", s, c);
        check("state_load", state, 3'd1);
        check("busy_accept", busy, 1'b1);
        finish_conv(eb, ee);
    endtask

    initial begin
        logic [6:0] eb;
        logic       ee;
        logic [7:0] first_code, second_code, samp;
        int         ndone;
        logic [1:0] rs;
        logic [7:0] rc;

        compared = 0;
        mismatched = 0;
        prev_bin = 7'd0;
        prev_err = 1'b0;
        rst = 1'b0; start = 1'b0; sel = 2'b00; code_in = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bin", bin_out, 7'd0);
        check("rst_err", err, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        run_conv(2'b00, 8'h0C);
        for (int g = 0; g < 16; g++) run_conv(2'b00, {4'($urandom), 4'(g)});

        run_conv(2'b01, 8'h47);
        run_conv(2'b01, 8'h99);
        run_conv(2'b01, 8'h5A);
        run_conv(2'b10, 8'h0C);
        run_conv(2'b10, 8'h03);
        run_conv(2'b10, 8'h02);
        run_conv(2'b10, 8'h0D);
        run_conv(2'b11, 8'($urandom));
        run_conv(2'b11, 8'h00);

        for (int i = 0; i < 30; i++) begin
            rs = 2'($urandom);
            rc = 8'($urandom);
            if (rs == 2'b01 && $urandom_range(1, 0) == 1)
                rc = {4'($urandom_range(9, 0)), 4'($urandom_range(9, 0))};
            run_conv(rs, rc);
        end

        // start held for ten edges while code_in keeps changing
        @(negedge clk);
        sel = 2'b00; code_in = 8'($urandom); start = 1'b1;
        first_code = code_in;
        second_code = 8'h00;
        ndone = 0;
        for (int e = 0; e < 10; e++) begin
            samp = code_in;
            @(posedge clk); #1;
            if (done === 1'b1) ndone++;
            if (e == 6) begin
                ref_model(2'b00, first_code, eb, ee);
                check("held_done", done, 1'b1);
                check("held_bin", bin_out, eb);
            end
            if (e == 7) check("held_idle", state, 3'd0);
            if (e == 8) begin
                check("held_reaccept", state, 3'd1);
                second_code = samp;
            end
            @(negedge clk);
            code_in = 8'($urandom);
            if (e == 9) start = 1'b0;
        end
        check("held_one_done", ndone, 1);
        prev_bin = eb;
        prev_err = ee;
        ref_model(2'b00, second_code, eb, ee);
        repeat (4) begin
            @(posedge clk); #1;
            check("held2_no_done", done, 1'b0);
        end
        @(posedge clk); #1;
        check("held2_done", done, 1'b1);
        check("held2_bin", bin_out, eb);
        prev_bin = eb;
        prev_err = ee;
        @(posedge clk); #1;
        check("held2_idle", state, 3'd0);
        $display("held-start test done pulses=%0d second code=%02h", ndone, second_code);

        // reset during CONV after a result of 47
        run_conv(2'b01, 8'h47);
        @(negedge clk);
        sel = 2'b01; code_in = 8'h99; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("abort_load", state, 3'd1);
        repeat (3) @(posedge clk);
        #1;
        check("abort_conv", state, 3'd2);
        check("abort_prev_bin", bin_out, 7'd47);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; code_in = 8'h25;
        @(posedge clk); #1;
        check("abort_state", state, 3'd0);
        check("abort_busy", busy, 1'b0);
        check("abort_bin", bin_out, 7'd0);
        check("abort_err", err, 1'b0);
        check("abort_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("after_rst_accept", state, 3'd1);
        prev_bin = 7'd0;
        prev_err = 1'b0;
        finish_conv(7'd25, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
